sym_slicer_mer: RTL and testbench

SYM_SLICER_MER -- requirements
Module: sym_slicer_mer

---
 rtl/sym_slicer_mer_pkg.sv | 37 +++
 rtl/sym_avg_acc.sv | 50 +++++
 rtl/sym_slicer_mer.sv | 179 +++++++++++++++++
 tb/tb_sym_slicer_mer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_slicer_mer_pkg.sv
// Shared constants, FSM state type and 1s17 saturation helpers for the
// symbol slicer / MER estimator.
package sym_slicer_mer_pkg;

    localparam int unsigned DW = 18;
    localparam int unsigned EW = DW + 1;

    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;

    localparam logic signed [DW-1:0] SAT_MAX = 18'sh1FFFF;
    localparam logic signed [DW-1:0] SAT_MIN = 18'sh20000;

    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Clamp a 19-bit intermediate back into the 1s17 range.
    function automatic logic signed [DW-1:0] sat_1s17(input logic signed [EW-1:0] x);
        if (x[EW-1] != x[EW-2]) begin
            return x[EW-1] ? SAT_MIN : SAT_MAX;
        end
        return $signed(x[DW-1:0]);
    endfunction

    // Magnitude with the single unrepresentable case (-1.0) pinned to full scale.
    function automatic logic [DW-1:0] abs_sat(input logic signed [DW-1:0] y);
        if (y == SAT_MIN) begin
            return $unsigned(SAT_MAX);
        end
        return y[DW-1] ? $unsigned(-y) : $unsigned(y);
    endfunction

endpackage

// File: rtl/sym_avg_acc.sv
// Accumulate-and-dump averager: sums din_i over a block of 2^LOG2 enables and
// registers the block mean, optionally dropping OUT_LSB low bits of the mean.
module sym_avg_acc #(
    parameter int unsigned W         = 18,
    parameter int unsigned LOG2      = 10,
    parameter int unsigned OUT_LSB   = 0,
    parameter int unsigned OW        = 18,
    parameter logic [OW-1:0] MEAN_INIT = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          dump_i,
    input  logic [W-1:0]  din_i,
    output logic [OW-1:0] mean_o
);

    localparam int unsigned AW = W + LOG2;

    logic [AW-1:0] acc_q, acc_d, sum_c;
    logic [OW-1:0] mean_q, mean_d;

    // The dumping sample is folded into the dumped sum, so every sample lands in exactly one block.
    always_comb begin
        sum_c  = acc_q + AW'(din_i);
        acc_d  = acc_q;
        mean_d = mean_q;
        if (en_i) begin
            if (dump_i) begin
                mean_d = OW'(sum_c >> (LOG2 + OUT_LSB));
                acc_d  = '0;
            end else begin
                acc_d  = sum_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            mean_q <= MEAN_INIT;
        end else begin
            acc_q  <= acc_d;
            mean_q <= mean_d;
        end
    end

    assign mean_o = mean_q;

endmodule

// File: rtl/sym_slicer_mer.sv
// 4-ASK symbol decimator and slicer with block-averaged reference level and
// mean-squared decision error estimation.
module sym_slicer_mer
    import sym_slicer_mer_pkg::*;
#(
    parameter int unsigned          LOG2_AVG = 10,
    parameter logic signed [DW-1:0] REF_INIT = 18'sd32768
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sam_clk_en,
    input  logic                 sym_clk_en,
    input  logic [1:0]           phase_sel,
    input  logic signed [DW-1:0] y_in,
    output logic [1:0]           sym_out,
    output logic                 sym_valid,
    output logic signed [DW-1:0] err,
    output logic signed [DW-1:0] ref_level,
    output logic [DW-1:0]        err_power,
    output logic                 ref_valid,
    output logic                 blk_done
);

    logic [1:0]           phase_q, phase_d;
    logic                 seen_q, seen_d;
    logic                 cap_c;
    logic                 cap_q;
    logic signed [DW-1:0] y_cap_q;

    state_t               state_q, state_d;
    logic [LOG2_AVG-1:0]  cnt_q;
    logic                 blk_end_c;

    logic signed [DW-1:0] r_c;
    logic signed [EW-1:0] r19, half19, lvl3_19, y19, ideal_c;
    logic [1:0]           sym_c;
    logic signed [DW-1:0] err_c;
    logic signed [2*DW-1:0] sq_c;
    logic [DW-1:0]        abs_c;
    logic [DW-1:0]        abs_mean;

    logic [1:0]           sym_q;
    logic signed [DW-1:0] err_q;
    logic                 sym_valid_q, blk_done_q, ref_valid_q;

    // Sample phase tracking; seen_q blocks a second capture after a mid-symbol phase_sel change.
    always_comb begin
        phase_d = phase_q;
        seen_d  = seen_q;
        cap_c   = 1'b0;
        if (sam_clk_en) begin
            phase_d = sym_clk_en ? 2'd0 : phase_q + 2'd1;
            cap_c   = (phase_d == phase_sel) && (sym_clk_en || !seen_q);
            seen_d  = (seen_q && !sym_clk_en) || cap_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            seen_q  <= 1'b0;
            cap_q   <= 1'b0;
            y_cap_q <= '0;
        end else begin
            phase_q <= phase_d;
            seen_q  <= seen_d;
            cap_q   <= cap_c;
            if (cap_c) begin
                y_cap_q <= y_in;
            end
        end
    end

    assign blk_end_c = cap_q && (cnt_q == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACQ:     if (blk_end_c) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = ACQ;
        endcase
    end

    // Decision thresholds at +/-R, ideal levels at +/-R/2 and +/-3R/2.
    assign r_c     = (state_q == TRACK) ? ref_level : REF_INIT;
    assign r19     = {r_c[DW-1], r_c};
    assign half19  = r19 >>> 1;
    assign lvl3_19 = r19 + half19;
    assign y19     = {y_cap_q[DW-1], y_cap_q};

    always_comb begin
        sym_c   = SYM_M3;
        ideal_c = -lvl3_19;
        if (y19 >= r19) begin
            sym_c   = SYM_P3;
            ideal_c = lvl3_19;
        end else if (y19 >= 19'sd0) begin
            sym_c   = SYM_P1;
            ideal_c = half19;
        end else if (y19 >= -r19) begin
            sym_c   = SYM_M1;
            ideal_c = -half19;
        end
        err_c = sat_1s17(y19 - ideal_c);
    end

    assign sq_c  = err_c * err_c;
    assign abs_c = abs_sat(y_cap_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_q       <= SYM_M3;
            err_q       <= '0;
            sym_valid_q <= 1'b0;
            blk_done_q  <= 1'b0;
            ref_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sym_valid_q <= cap_q;
            blk_done_q  <= blk_end_c;
            if (cap_q) begin
                sym_q <= sym_c;
                err_q <= err_c;
                cnt_q <= cnt_q + LOG2_AVG'(1);
            end
            if (blk_end_c) begin
                ref_valid_q <= 1'b1;
            end
        end
    end

    sym_avg_acc #(
        .W         (DW),
        .LOG2      (LOG2_AVG),
        .OUT_LSB   (0),
        .OW        (DW),
        .MEAN_INIT ($unsigned(REF_INIT))
    ) u_abs_acc (
        .clk    (clk),
        .reset  (reset),
        .en_i   (cap_q),
        .dump_i (blk_end_c),
        .din_i  (abs_c),
        .mean_o (abs_mean)
    );

    // Mean of the 2s34 squared error, reported as bits [34:17].
    sym_avg_acc #(
        .W         (2*DW),
        .LOG2      (LOG2_AVG),
        .OUT_LSB   (17),
        .OW        (DW),
        .MEAN_INIT ('0)
    ) u_sq_acc (
        .clk    (clk),
        .reset  (reset),
        .en_i   (cap_q),
        .dump_i (blk_end_c),
        .din_i  ($unsigned(sq_c)),
        .mean_o (err_power)
    );

    assign ref_level = $signed(abs_mean);
    assign sym_out   = sym_q;
    assign err       = err_q;
    assign sym_valid = sym_valid_q;
    assign blk_done  = blk_done_q;
    assign ref_valid = ref_valid_q;

endmodule

// File: tb/tb_sym_slicer_mer.sv
// Directed bench for sym_slicer_mer: a reference model feeds a scoreboard of
// decisions and block results that a negedge monitor checks against the DUT.
module tb_sym_slicer_mer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, sam_clk_en, sym_clk_en;
    logic [1:0]         phase_sel;
    logic signed [17:0] y_in;

    logic [1:0]         sym_out, sym_out4;
    logic               sym_valid, sym_valid4, ref_valid, ref_valid4, blk_done, blk_done4;
    logic signed [17:0] err, err4, ref_level, ref_level4;
    logic [17:0]        err_power, err_power4;

    sym_slicer_mer #(.LOG2_AVG(2)) dut (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .phase_sel(phase_sel), .y_in(y_in), .sym_out(sym_out), .sym_valid(sym_valid),
        .err(err), .ref_level(ref_level), .err_power(err_power),
        .ref_valid(ref_valid), .blk_done(blk_done)
    );

    sym_slicer_mer #(.LOG2_AVG(4)) dut4 (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .phase_sel(phase_sel), .y_in(y_in), .sym_out(sym_out4), .sym_valid(sym_valid4),
        .err(err4), .ref_level(ref_level4), .err_power(err_power4),
        .ref_valid(ref_valid4), .blk_done(blk_done4)
    );

    int tests = 0;
    int fails = 0;
    int q_sym[$], q_err[$], q_ref[$], q_ep[$], q4[$];
    int mdl_r, mdl_cnt;
    longint mdl_abs, mdl_sq;
    int sv_cnt = 0;
    int blk_cnt = 0;
    int samp_idx = 0;
    bit chk4 = 1'b0;
    int vals4[4]  = '{49152, 16384, -16384, -49152};
    int codes4[4] = '{3, 2, 1, 0};

    task automatic check(input string tag, input logic signed [39:0] obs,
                         input logic signed [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mdl_r   = 32768;
        mdl_cnt = 0;
        mdl_abs = 0;
        mdl_sq  = 0;
    endtask

    // Reference slicer + block averager (LOG2_AVG=2 instance).
    task automatic model_push(input int y);
        int r, half, l3, ideal, e, a, s;
        r = mdl_r; half = r >>> 1; l3 = r + half;
        if (y >= r)       begin s = 3; ideal = l3;    end
        else if (y >= 0)  begin s = 2; ideal = half;  end
        else if (y >= -r) begin s = 1; ideal = -half; end
        else              begin s = 0; ideal = -l3;   end
        e = y - ideal;
        if (e > 131071) e = 131071;
        else if (e < -131072) e = -131072;
        q_sym.push_back(s);
        q_err.push_back(e);
        a = (y == -131072) ? 131071 : ((y < 0) ? -y : y);
        mdl_abs += longint'(a);
        mdl_sq  += longint'(e) * longint'(e);
        mdl_cnt++;
        if (mdl_cnt == 4) begin
            mdl_r = int'(mdl_abs >> 2);
            q_ref.push_back(mdl_r);
            q_ep.push_back(int'(((mdl_sq >> 2) >> 17) & 64'h3FFFF));
            mdl_abs = 0; mdl_sq = 0; mdl_cnt = 0;
        end
    endtask

    // One symbol = 4 samples, 4 clk apart; phase_sel switches to sel_late before sample 2.
    task automatic send_sym(input int y, input logic [1:0] sel, input logic [1:0] sel_late,
                            input bit idx_mode);
        bit got;
        int v;
        got = 1'b0;
        phase_sel = sel;
        for (int p = 0; p < 4; p++) begin
            if (p == 2) phase_sel = sel_late;
            @(posedge clk); #1;
            if (idx_mode) v = samp_idx;
            else if (!got && int'(phase_sel) == p) v = y;
            else v = 100000 - 40000 * p;
            if (!got && int'(phase_sel) == p) begin
                got = 1'b1;
                model_push(v);
            end
            sam_clk_en = 1'b1;
            sym_clk_en = (p == 0);
            y_in = 18'(v);
            samp_idx++;
            @(posedge clk); #1;
            sam_clk_en = 1'b0;
            sym_clk_en = 1'b0;
            repeat (2) @(posedge clk);
        end
        #1;
    endtask

    task automatic reset_on();
        check("sb_drained", q_sym.size(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        q_ref.delete(); q_ep.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_off();
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (sym_valid) begin
            sv_cnt++;
            if (q_sym.size() == 0) check("sym_valid_unexpected", sym_valid, 0);
            else begin
                check("sym_out", sym_out, q_sym.pop_front());
                check("err", err, q_err.pop_front());
            end
        end
        if (blk_done) begin
            blk_cnt++;
            if (q_ref.size() == 0) check("blk_done_unexpected", blk_done, 0);
            else begin
                check("ref_level_blk", ref_level, q_ref.pop_front());
                check("err_power_blk", err_power, q_ep.pop_front());
            end
        end
        if (chk4 && sym_valid4) begin
            if (q4.size() == 0) check("sym_valid4_unexpected", sym_valid4, 0);
            else check("sym_out4", sym_out4, q4.pop_front());
            check("err4_zero", err4, 0);
        end
    end

    initial begin
        int base;
        reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
        phase_sel = 2'd2; y_in = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_out", sym_out, 0);
        check("rst_err", err, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_blk_done", blk_done, 0);
        check("rst_ref_valid", ref_valid, 0);
        check("rst_err_power", err_power, 0);
        check("rst_ref_level", ref_level, 32768);
        reset_off();

        // Symbol timing: y_in = sample index, only the third sample is taken.
        samp_idx = 0;
        base = sv_cnt;
        send_sym(0, 2'd2, 2'd2, 1'b1);
        send_sym(0, 2'd2, 2'd2, 1'b1);
        check("sym_valid_per_symbol", sv_cnt - base, 2);
        reset_on(); reset_off();

        // Constant level, then reset in the middle of the next block.
        base = blk_cnt;
        repeat (4) send_sym(49152, 2'd2, 2'd2, 1'b0);
        check("const_ref_level", ref_level, 49152);
        check("const_ref_valid", ref_valid, 1);
        check("const_blk_once", blk_cnt - base, 1);
        check("const_err_power", err_power, 0);
        send_sym(49152, 2'd2, 2'd2, 1'b0);
        check("next_sym_out", sym_out, 3);
        check("next_err", err, -24576);
        send_sym(20000, 2'd2, 2'd2, 1'b0);
        reset_on();
        check("midrst_sym_out", sym_out, 0);
        check("midrst_err", err, 0);
        check("midrst_sym_valid", sym_valid, 0);
        check("midrst_blk_done", blk_done, 0);
        check("midrst_ref_valid", ref_valid, 0);
        check("midrst_err_power", err_power, 0);
        check("midrst_ref_level", ref_level, 32768);
        reset_off();
        base = blk_cnt;
        send_sym(20000, 2'd2, 2'd2, 1'b0);
        send_sym(-30000, 2'd2, 2'd2, 1'b0);
        send_sym(10000, 2'd2, 2'd2, 1'b0);
        check("midrst_no_early_blk", blk_cnt - base, 0);
        send_sym(-40000, 2'd2, 2'd2, 1'b0);
        check("midrst_blk_after_4", blk_cnt - base, 1);
        check("midrst_ref_level_new", ref_level, 25000);

        // Slicer boundaries in TRACK with R = 32768.
        reset_on(); reset_off();
        repeat (4) send_sym(32768, 2'd2, 2'd2, 1'b0);
        check("bnd_ref_valid", ref_valid, 1);
        check("bnd_ref_level", ref_level, 32768);
        send_sym(0, 2'd2, 2'd2, 1'b0);
        send_sym(32768, 2'd2, 2'd2, 1'b0);
        send_sym(-32768, 2'd2, 2'd2, 1'b0);
        send_sym(-32769, 2'd2, 2'd2, 1'b0);
        check("bnd_last_sym", sym_out, 0);

        // Negative full scale at R = 49152.
        reset_on(); reset_off();
        repeat (4) send_sym(49152, 2'd2, 2'd2, 1'b0);
        repeat (4) send_sym(-131072, 2'd2, 2'd2, 1'b0);
        check("sat_sym_out", sym_out, 0);
        check("sat_err", err, -57344);
        check("sat_ref_level", ref_level, 131071);
        check("sat_err_power", err_power, 25088);

        // Mid-symbol phase_sel changes never capture twice.
        reset_on(); reset_off();
        base = sv_cnt;
        send_sym(-5000, 2'd1, 2'd3, 1'b0);
        send_sym(9000, 2'd3, 2'd3, 1'b0);
        send_sym(0, 2'd2, 2'd0, 1'b0);
        check("phase_change_captures", sv_cnt - base, 2);
        phase_sel = 2'd2;

        // Uniform 4-ASK on the 16-symbol averager.
        reset_on(); reset_off();
        chk4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("ask_ref_valid4_pre", ref_valid4, 0);
            q4.push_back(codes4[i % 4]);
            send_sym(vals4[i % 4], 2'd2, 2'd2, 1'b0);
        end
        chk4 = 1'b0;
        check("ask_ref_level4", ref_level4, 32768);
        check("ask_err_power4", err_power4, 0);
        check("ask_ref_valid4", ref_valid4, 1);
        check("ask_q4_drained", q4.size(), 0);
        check("final_sb_drained", q_sym.size(), 0);
        check("final_blk_drained", q_ref.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
